// File: rtl/updown_tick_counter.sv
// Up/down counter stepped by an internal prescaler with an optional slow-rate divider.
// Supports wrap or saturate at the limits and emits a one-cycle tick per step.
module updown_tick_counter #(
  parameter int WIDTH     = 4,
  parameter int TICK_DIV  = 100000000,
  parameter int SLOW_MULT = 4,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk_1,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             mode,
  input  logic             switch,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             wrap,
  output logic             tc
);

  localparam int PW = $clog2(TICK_DIV);
  // A one-step slow divider still needs a 1-bit register to stay legal.
  localparam int SW = (SLOW_MULT > 1) ? $clog2(SLOW_MULT) : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    SLOW_LAST = SW'(SLOW_MULT - 1);
  localparam logic [WIDTH-1:0] MAX_VAL   = '1;

  logic [PW-1:0]    pre;
  logic [SW-1:0]    slow;
  logic             base_tick;
  logic             step;
  logic             at_limit;
  logic [WIDTH-1:0] next_count;

  assign base_tick  = en & (pre == PRE_LAST);
  assign step       = base_tick & (~switch | (slow == SLOW_LAST));
  assign at_limit   = mode ? (counter == '0) : (counter == MAX_VAL);
  assign next_count = mode ? (counter - WIDTH'(1)) : (counter + WIDTH'(1));
  assign tc         = at_limit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end

  // Leaving slow mode discards the partial count so the next base tick steps.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      slow <= '0;
    end else if (clr || !switch) begin
      slow <= '0;
    end else if (base_tick) begin
      slow <= (slow == SLOW_LAST) ? '0 : slow + SW'(1);
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (clr) begin
      counter <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (load) begin
      counter <= load_val;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (step) begin
      tick <= 1'b1;
      if (SATURATE && at_limit) begin
        counter <= counter;
        wrap    <= 1'b0;
      end else begin
        counter <= next_count;
        wrap    <= at_limit;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_tick_counter.sv
// Bench for updown_tick_counter: a wrapping and a saturating instance share stimulus
// and are compared against an integer-level model, a vector table and corner sequences.
module tb_updown_tick_counter;

  localparam int W  = 4;
  localparam int TD = 5;
  localparam int SM = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk_1 = 1'b0;
  logic rst_n, en, clr, mode, switch, load;
  logic [W-1:0] load_val;
  logic [W-1:0] c0, c1;
  logic t0, t1, w0, w1, tc0, tc1;

  always #5 clk_1 = ~clk_1;

  updown_tick_counter #(.WIDTH(W), .TICK_DIV(TD), .SLOW_MULT(SM), .SATURATE(1'b0)) dut_wrap (
    .clk_1(clk_1), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .switch(switch),
    .load(load), .load_val(load_val), .counter(c0), .tick(t0), .wrap(w0), .tc(tc0));

  updown_tick_counter #(.WIDTH(W), .TICK_DIV(TD), .SLOW_MULT(SM), .SATURATE(1'b1)) dut_sat (
    .clk_1(clk_1), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .switch(switch),
    .load(load), .load_val(load_val), .counter(c1), .tick(t1), .wrap(w1), .tc(tc1));

  int checks = 0;
  int errors = 0;

  // Model: enabled cycles elapsed within the base period, base ticks elapsed
  // within the slow period, and one integer count per instance (0: wrap, 1: saturate).
  int m_elapsed, m_bases;
  int m_cnt[2];
  bit m_tick[2], m_wrap[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_elapsed = 0;
    m_bases   = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_tick[k] = 0;
      m_wrap[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit base, stepping;
    int nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (clr) begin
      model_reset();
      return;
    end
    base     = en && (m_elapsed == TD - 1);
    stepping = base && (!switch || m_bases == SM - 1);
    if (en) m_elapsed = (m_elapsed + 1) % TD;
    if (!switch) m_bases = 0;
    else if (base) m_bases = (m_bases + 1) % SM;
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 0;
      m_wrap[k] = 0;
      if (load) begin
        m_cnt[k] = int'(load_val);
      end else if (stepping) begin
        m_tick[k] = 1;
        nxt = mode ? m_cnt[k] - 1 : m_cnt[k] + 1;
        if (nxt < 0 || nxt > MAXV) begin
          if (k == 0) begin
            m_cnt[k]  = (nxt + MAXV + 1) % (MAXV + 1);
            m_wrap[k] = 1;
          end
        end else begin
          m_cnt[k] = nxt;
        end
      end
    end
  endtask

  function automatic int exp_tc(input int cnt);
    return mode ? int'(cnt == 0) : int'(cnt == MAXV);
  endfunction

  task automatic compare_all();
    check("cnt_wrap",  int'(c0),  m_cnt[0]);
    check("tick_wrap", int'(t0),  int'(m_tick[0]));
    check("wrap_wrap", int'(w0),  int'(m_wrap[0]));
    check("tc_wrap",   int'(tc0), exp_tc(m_cnt[0]));
    check("cnt_sat",   int'(c1),  m_cnt[1]);
    check("tick_sat",  int'(t1),  int'(m_tick[1]));
    check("wrap_sat",  int'(w1),  int'(m_wrap[1]));
    check("tc_sat",    int'(tc1), exp_tc(m_cnt[1]));
  endtask

  task automatic cycle(input bit e, input bit c, input bit l, input bit m, input bit s,
                       input logic [W-1:0] lv);
    en = e; clr = c; load = l; mode = m; switch = s; load_val = lv;
    @(posedge clk_1);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    bit en, clr, load, mode, sw;
    logic [W-1:0] lv;
    int ncyc;
    int cnt, tick, wrap, tc, cnt_s, wrap_s;
  } vec_t;

  function automatic vec_t mk(input bit e, input bit c, input bit l, input bit m, input bit s,
                              input int lv, input int n, input int cnt, input int tk,
                              input int wr, input int tcv, input int cs, input int ws);
    vec_t v;
    v.en = e; v.clr = c; v.load = l; v.mode = m; v.sw = s; v.lv = W'(lv); v.ncyc = n;
    v.cnt = cnt; v.tick = tk; v.wrap = wr; v.tc = tcv; v.cnt_s = cs; v.wrap_s = ws;
    return v;
  endfunction

  vec_t tbl[$];
  bit seen;
  bit r_en, r_clr, r_load, r_mode, r_sw;

  initial begin
    // Expected values follow the step-period, priority and limit rules directly.
    //             en clr ld md sw lv  n   cnt tk wr tc  cs  ws
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  4,   0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1,   1, 1, 0, 0,  1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  5,   2, 1, 0, 0,  2, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1,   2, 0, 0, 0,  2, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 14, 1,  14, 0, 0, 0, 14, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2,  14, 0, 0, 0, 14, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1,  15, 1, 0, 1, 15, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  5,   0, 1, 1, 0, 15, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0,  5,  15, 1, 1, 0, 14, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0,  5,  14, 1, 0, 0, 13, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 1,  1,   1, 0, 0, 0,  1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0,  4,   0, 1, 0, 1,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  4,   0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  1,   0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  4,   0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 7,  1,   7, 0, 0, 0,  7, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  5,   8, 1, 0, 0,  8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2,   8, 0, 0, 0,  8, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12,   8, 0, 0, 0,  8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2,   8, 0, 0, 0,  8, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  1,   9, 1, 0, 0,  9, 0));

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; mode = 1'b0; switch = 1'b0; load = 1'b0;
    load_val = '0;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int n = 0; n < tbl[i].ncyc; n++)
        cycle(tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].mode, tbl[i].sw, tbl[i].lv);
      check($sformatf("vec%0d_cnt", i),    int'(c0),  tbl[i].cnt);
      check($sformatf("vec%0d_tick", i),   int'(t0),  tbl[i].tick);
      check($sformatf("vec%0d_wrap", i),   int'(w0),  tbl[i].wrap);
      check($sformatf("vec%0d_tc", i),     int'(tc0), tbl[i].tc);
      check($sformatf("vec%0d_cnt_s", i),  int'(c1),  tbl[i].cnt_s);
      check($sformatf("vec%0d_wrap_s", i), int'(w1),  tbl[i].wrap_s);
    end

    // Slow rate: from a cleared state the first step lands 20 cycles later.
    cycle(1, 1, 0, 0, 0, 0);
    for (int n = 0; n < TD * SM - 1; n++) begin
      cycle(1, 0, 0, 0, 1, 0);
      check("slow_quiet", int'(t0), 0);
    end
    cycle(1, 0, 0, 0, 1, 0);
    check("slow_step_tick", int'(t0), 1);
    check("slow_step_cnt", int'(c0), 1);

    // Leaving slow mode mid-period: the next base tick steps, within TICK_DIV cycles.
    for (int n = 0; n < 7; n++) cycle(1, 0, 0, 0, 1, 0);
    seen = 0;
    for (int n = 0; n < TD && !seen; n++) begin
      cycle(1, 0, 0, 0, 0, 0);
      seen = (t0 === 1'b1);
    end
    check("switch_off_step_seen", int'(seen), 1);
    check("switch_off_cnt", int'(c0), 2);

    // Down-count at zero: the wrapping copy goes to MAX, the saturating copy holds.
    cycle(1, 0, 1, 1, 0, 0);
    seen = 0;
    for (int n = 0; n < TD && !seen; n++) begin
      cycle(1, 0, 0, 1, 0, 0);
      seen = (t0 === 1'b1);
    end
    check("down_zero_seen", int'(seen), 1);
    check("down_zero_wrap_cnt", int'(c0), MAXV);
    check("down_zero_wrap_flag", int'(w0), 1);
    check("down_zero_sat_cnt", int'(c1), 0);
    check("down_zero_sat_tick", int'(t1), 1);
    check("down_zero_sat_flag", int'(w1), 0);

    // Asynchronous reset between edges clears the count without a clock edge.
    cycle(1, 0, 1, 0, 0, 9);
    cycle(1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cnt", int'(c0), 0);
    check("async_rst_cnt_s", int'(c1), 0);
    model_reset();
    @(negedge clk_1);
    rst_n = 1'b1;
    for (int n = 0; n < TD - 1; n++) begin
      cycle(1, 0, 0, 0, 0, 0);
      check("post_rst_quiet", int'(t0), 0);
    end
    cycle(1, 0, 0, 0, 0, 0);
    check("post_rst_first_tick", int'(t0), 1);
    check("post_rst_first_cnt", int'(c0), 1);

    // Randomized traffic against the model; control changes are kept sparse.
    r_mode = 0; r_sw = 0;
    for (int n = 0; n < 3000; n++) begin
      r_en   = ($urandom_range(0, 9) != 0);
      r_clr  = ($urandom_range(0, 63) == 0);
      r_load = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 49) == 0) r_mode = ~r_mode;
      if ($urandom_range(0, 79) == 0) r_sw = ~r_sw;
      cycle(r_en, r_clr, r_load, r_mode, r_sw, W'($urandom_range(0, MAXV)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
